// File: rtl/blk_arb_pkg.sv
// Shared types and default sizing for the block-memory arbiter.
package blk_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned BLK_W_DEF   = 256;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_I_RD,
    ST_D_RD,
    ST_D_WR,
    ST_DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/blk_arb_watchdog.sv
// Transfer watchdog: counts cycles spent in a transfer state and flags the
// last permitted cycle (count == TIMEOUT-1).
module blk_arb_watchdog
  import blk_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Cycle counter, cleared while idle and advanced while a transfer is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count marks the final cycle a valid can still arrive.
  always_comb begin
    tc = (count == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/blk_mem_arbiter.sv
// Shares one block-memory port between the I-cache fill path and the D-cache
// fill/writeback path: one transaction at a time, round-robin I/D, with a
// watchdog that aborts transfers the memory never completes.
module blk_mem_arbiter
  import blk_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned BLK_W   = BLK_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [BLK_W-1:0]  i_rdata,
  output logic              i_done,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic [BLK_W-1:0]  d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  output logic              mem_blk_read,
  output logic              mem_blk_write,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_read_valid,
  input  logic              mem_write_valid,
  output logic              err,
  output logic              busy
);

  arb_state_t state, state_nx;
  owner_t     owner, owner_nx;
  logic       last_d;
  logic       d_any;
  logic       grant, grant_d;
  logic       rd_hit, to_hit;
  logic       xfer, wd_tc;

  // Watchdog runs only while a transfer state is open.
  always_comb begin
    d_any = d_rd_req | d_wr_req;
    xfer  = (state == ST_I_RD) || (state == ST_D_RD) || (state == ST_D_WR);
  end

  blk_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (state == ST_IDLE),
    .en    (xfer),
    .tc    (wd_tc)
  );

  // Next-state: arbitration in IDLE, completion or timeout in transfer states.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    grant    = 1'b0;
    grant_d  = 1'b0;
    rd_hit   = 1'b0;
    to_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req || d_any) begin
          grant   = 1'b1;
          grant_d = (i_req && d_any) ? !last_d : d_any;
          if (grant_d) begin
            owner_nx = OWN_D;
            state_nx = d_wr_req ? ST_D_WR : ST_D_RD;
          end else begin
            owner_nx = OWN_I;
            state_nx = ST_I_RD;
          end
        end
      end
      ST_I_RD, ST_D_RD: begin
        if (mem_read_valid) begin
          rd_hit   = 1'b1;
          state_nx = ST_DONE;
        end else if (wd_tc) begin
          to_hit   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_D_WR: begin
        if (mem_write_valid) begin
          state_nx = ST_DONE;
        end else if (wd_tc) begin
          to_hit   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, owner and round-robin flag; last_d=1 out of reset lets I win the first tie.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= ST_IDLE;
      owner  <= OWN_I;
      last_d <= 1'b1;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      if (grant) begin
        last_d <= grant_d;
      end
    end
  end

  // Address/data captured at grant; fill data captured on valid, zeroed on timeout.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant) begin
        mem_addr <= grant_d ? d_addr : i_addr;
        if (grant_d && d_wr_req) begin
          mem_wdata <= d_wdata;
        end
      end
      if (rd_hit || to_hit) begin
        if (owner == OWN_I) begin
          i_rdata <= rd_hit ? mem_rdata : '0;
        end else begin
          d_rdata <= rd_hit ? mem_rdata : '0;
        end
      end
    end
  end

  // Status outputs are flopped from the next state so they line up with the
  // state register while staying free of input-to-output paths.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_blk_read  <= 1'b0;
      mem_blk_write <= 1'b0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      err           <= 1'b0;
      busy          <= 1'b0;
    end else begin
      mem_blk_read  <= (state_nx == ST_I_RD) || (state_nx == ST_D_RD);
      mem_blk_write <= (state_nx == ST_D_WR);
      i_done        <= (state_nx == ST_DONE) && (owner_nx == OWN_I);
      d_done        <= (state_nx == ST_DONE) && (owner_nx == OWN_D);
      err           <= to_hit;
      busy          <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// Self-checking bench for blk_mem_arbiter: directed vector table, hand-built
// multi-cycle sequences, and a randomized run against a transaction model.
module tb_blk_mem_arbiter;

  localparam int TO = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         i_req, d_rd_req, d_wr_req;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic         i_done, d_done, mem_blk_read, mem_blk_write;
  logic         mem_read_valid, mem_write_valid, err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           kind;     // 0 = I read, 1 = D read, 2 = D write
    logic [31:0]  addr;
    logic [255:0] data;     // fill data, or write data for kind 2
    int           vdly;     // cycles after strobe rise that valid appears (255 = never)
    bit           stray;    // drive the opposite valid throughout the transfer
    int           exp_d;    // expected cycles from strobe rise to done
    bit           exp_err;
  } vec_t;

  vec_t vecs[8];

  blk_mem_arbiter #(.ADDR_W(32), .BLK_W(256), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_blk_read(mem_blk_read), .mem_blk_write(mem_blk_write),
    .mem_rdata(mem_rdata), .mem_read_valid(mem_read_valid),
    .mem_write_valid(mem_write_valid), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_chk(input string nm);
    chk(nm, 32'({mem_blk_read, mem_blk_write, i_done, d_done, busy, err}), 32'd0);
  endtask

  task automatic all_zero_chk(input string nm);
    idle_chk(nm);
    chk({nm, "_addr"}, mem_addr, 32'd0);
    chk_blk({nm, "_wdata"}, mem_wdata, '0);
    chk_blk({nm, "_irdata"}, i_rdata, '0);
    chk_blk({nm, "_drdata"}, d_rdata, '0);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    i_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    mem_read_valid = 1'b0; mem_write_valid = 1'b0;
    tick();
    tick();
    all_zero_chk("reset");
    RESET = 1'b1;
    tick();
  endtask

  // Called with the strobe visible; walks the transfer to done and drops the request.
  task automatic serve(input int kind, input logic [31:0] a, input logic [255:0] wd,
                       input logic [255:0] dat, input int vdly, input bit stray,
                       input int exp_d, input bit exp_err);
    logic [4:0] e;
    for (int k = 0; k <= exp_d; k++) begin
      if (k < exp_d) begin
        e = {kind != 2, kind == 2, 3'b001};
        chk("xfer_flags", 32'({mem_blk_read, mem_blk_write, i_done, d_done, busy}), 32'(e));
        chk("xfer_addr", mem_addr, a);
        if (kind == 2) chk_blk("xfer_wdata", mem_wdata, wd);
        mem_read_valid  = (kind != 2) ? (k == vdly) : stray;
        mem_write_valid = (kind == 2) ? (k == vdly) : stray;
        mem_rdata       = (k == vdly) ? dat : rnd256();
        if (kind == 0) i_addr = $urandom;
        if (kind == 2) d_wdata = rnd256();
      end else begin
        e = {2'b00, kind == 0, kind != 0, 1'b1};
        chk("done_flags", 32'({mem_blk_read, mem_blk_write, i_done, d_done, busy}), 32'(e));
        chk("done_err", 32'(err), 32'(exp_err));
        if (kind == 0) chk_blk("i_rdata", i_rdata, exp_err ? '0 : dat);
        if (kind == 1) chk_blk("d_rdata", d_rdata, exp_err ? '0 : dat);
        if (kind == 0) i_req = 1'b0;
        else if (kind == 1) d_rd_req = 1'b0;
        else d_wr_req = 1'b0;
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.kind == 0) begin
      i_addr = v.addr; i_req = 1'b1;
    end else begin
      d_addr = v.addr; d_wdata = v.data;
      if (v.kind == 1) d_rd_req = 1'b1; else d_wr_req = 1'b1;
    end
    tick();
    serve(v.kind, v.addr, v.data, v.data, v.vdly, v.stray, v.exp_d, v.exp_err);
    idle_chk("vec_idle");
  endtask

  // Randomized run against a transaction-level model of grant order and timing.
  task automatic random_run(input int cycles);
    bit m_act = 0, m_last_d = 1, m_err = 0;
    int m_kind = 0, m_rise = 0, m_done_at = 0, m_vcyc = -1, vd, sel, r;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_wd = '0, m_data = '0;
    logic [4:0] e;
    bit i_just, d_just, is_idle, gd, in_x, real_v, stray;
    for (int t = 0; t < cycles; t++) begin
      i_just = 0; d_just = 0; is_idle = 0;
      if (m_act && t < m_done_at) begin
        e = {m_kind != 2, m_kind == 2, 3'b001};
        chk("rnd_xfer", 32'({mem_blk_read, mem_blk_write, i_done, d_done, busy}), 32'(e));
        chk("rnd_addr", mem_addr, m_addr);
        if (m_kind == 2) chk_blk("rnd_wdata", mem_wdata, m_wd);
      end else if (m_act && t == m_done_at) begin
        e = {2'b00, m_kind == 0, m_kind != 0, 1'b1};
        chk("rnd_done", 32'({mem_blk_read, mem_blk_write, i_done, d_done, busy}), 32'(e));
        chk("rnd_err", 32'(err), 32'(m_err));
        if (m_kind == 0) chk_blk("rnd_irdata", i_rdata, m_err ? '0 : m_data);
        if (m_kind == 1) chk_blk("rnd_drdata", d_rdata, m_err ? '0 : m_data);
        if (m_kind == 0) begin i_req = 1'b0; i_just = 1; end
        else if (m_kind == 1) begin d_rd_req = 1'b0; d_just = 1; end
        else begin d_wr_req = 1'b0; d_just = 1; end
        m_act = 0;
      end else begin
        is_idle = 1;
        idle_chk("rnd_idle");
      end
      if (!i_req && !i_just && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_rd_req && !d_wr_req && !d_just && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        d_wr_req = (r != 1); d_rd_req = (r != 0);
        d_addr = $urandom; d_wdata = rnd256();
      end
      if (is_idle && (i_req || d_rd_req || d_wr_req)) begin
        gd       = (i_req && (d_rd_req || d_wr_req)) ? !m_last_d : !i_req;
        m_kind   = !gd ? 0 : (d_wr_req ? 2 : 1);
        m_addr   = gd ? d_addr : i_addr;
        m_wd     = d_wdata;
        m_last_d = gd;
        m_rise   = t + 1;
        sel      = $urandom_range(0, 9);
        vd       = (sel < 7) ? $urandom_range(0, 4) : (sel == 7) ? TO - 1 : (sel == 8) ? TO : 255;
        m_err    = (vd >= TO);
        m_done_at = m_rise + (m_err ? TO : vd + 1);
        m_vcyc   = m_err ? -1 : m_rise + vd;
        m_data   = rnd256();
        m_act    = 1;
      end
      in_x   = m_act && t >= m_rise && t < m_done_at;
      real_v = m_act && t == m_vcyc;
      stray  = ($urandom_range(0, 7) == 0);
      mem_read_valid  = (real_v && m_kind != 2) || (stray && !(in_x && m_kind != 2));
      mem_write_valid = (real_v && m_kind == 2) || (stray && !(in_x && m_kind == 2));
      mem_rdata       = real_v ? m_data : rnd256();
      if (m_act && t >= m_rise && m_kind == 0) i_addr = $urandom;
      if (m_act && t >= m_rise && m_kind == 2) d_wdata = rnd256();
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'h0040_0020, {32{8'hA5}}, 4,   1'b0, 5, 1'b0};
    vecs[1] = '{1, 32'h1000_0040, {32{8'h3C}}, 0,   1'b0, 1, 1'b0};
    vecs[2] = '{2, 32'h1000_0080, {32{8'h5A}}, 2,   1'b0, 3, 1'b0};
    vecs[3] = '{0, 32'h0040_0040, {32{8'h77}}, 7,   1'b0, 8, 1'b0};
    vecs[4] = '{1, 32'h1000_0100, {32{8'hEE}}, 255, 1'b0, 8, 1'b1};
    vecs[5] = '{0, 32'h0040_0060, {32{8'h96}}, 3,   1'b1, 4, 1'b0};
    vecs[6] = '{2, 32'h1000_0140, {32{8'hC3}}, 255, 1'b0, 8, 1'b1};
    vecs[7] = '{2, 32'h1000_0180, {32{8'h0F}}, 1,   1'b1, 2, 1'b0};

    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    do_reset();

    // Tie out of reset: I first, then D.
    i_addr = 32'h0040_0100; d_addr = 32'h1000_0200;
    i_req = 1'b1; d_rd_req = 1'b1;
    tick();
    serve(0, 32'h0040_0100, '0, {32{8'h11}}, 1, 1'b0, 2, 1'b0);
    idle_chk("pair1_gap");
    tick();
    serve(1, 32'h1000_0200, '0, {32{8'h22}}, 2, 1'b0, 3, 1'b0);
    idle_chk("pair1_end");

    // After a lone I grant, a tie goes to D.
    run_vec('{0, 32'h0040_0200, {32{8'h33}}, 0, 1'b0, 1, 1'b0});
    i_addr = 32'h0040_0300; d_addr = 32'h1000_0300;
    i_req = 1'b1; d_rd_req = 1'b1;
    tick();
    serve(1, 32'h1000_0300, '0, {32{8'h44}}, 1, 1'b0, 2, 1'b0);
    idle_chk("pair2_gap");
    tick();
    serve(0, 32'h0040_0300, '0, {32{8'h55}}, 0, 1'b0, 1, 1'b0);
    idle_chk("pair2_end");

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Write and read together: writeback strictly before fill.
    d_addr = 32'h1000_0040; d_wdata = {32{8'hB7}};
    d_wr_req = 1'b1; d_rd_req = 1'b1;
    tick();
    serve(2, 32'h1000_0040, {32{8'hB7}}, '0, 1, 1'b0, 2, 1'b0);
    idle_chk("wrrd_gap");
    tick();
    serve(1, 32'h1000_0040, '0, {32{8'h6D}}, 3, 1'b0, 4, 1'b0);
    idle_chk("wrrd_end");

    // Reset mid-I_RD: strobe drops immediately, no done, reissue completes.
    i_addr = 32'h0040_0400; i_req = 1'b1;
    tick();
    chk("rst_pre_strobe", 32'(mem_blk_read), 32'd1);
    RESET = 1'b0;
    #1;
    chk("rst_async_drop", 32'({mem_blk_read, mem_blk_write, busy}), 32'd0);
    i_req = 1'b0;
    tick();
    chk("rst_no_done", 32'({i_done, d_done}), 32'd0);
    RESET = 1'b1;
    tick();
    idle_chk("rst_idle");
    i_addr = 32'h0040_0400; i_req = 1'b1;
    tick();
    serve(0, 32'h0040_0400, '0, {32{8'h99}}, 2, 1'b0, 3, 1'b0);
    idle_chk("rst_reissue_end");

    do_reset();
    random_run(800);

    i_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0;
    mem_read_valid = 1'b0; mem_write_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
